// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared opcodes, FSM state type and instruction field helpers
//            for the parametrised multi-cycle RISC core.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package risc_pkg;

    // Widest instruction word the field helpers can slice.
    localparam int MAX_IW = 64;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00110;
    localparam logic [4:0] OP_CMP  = 5'b00111;
    localparam logic [4:0] OP_IN   = 5'b01000;
    localparam logic [4:0] OP_OUT  = 5'b01001;
    localparam logic [4:0] OP_MOVI = 5'b01010;
    localparam logic [4:0] OP_LD   = 5'b01011;
    localparam logic [4:0] OP_ST   = 5'b01100;
    localparam logic [4:0] OP_JMP  = 5'b01101;
    localparam logic [4:0] OP_JZ   = 5'b01110;
    localparam logic [4:0] OP_JC   = 5'b01111;
    localparam logic [4:0] OP_PUSH = 5'b10000;
    localparam logic [4:0] OP_POP  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Generic right-justified field extraction.
    function automatic logic [MAX_IW-1:0] f_slice(input logic [MAX_IW-1:0] iw,
                                                  input int lsb, input int w);
        logic [MAX_IW-1:0] mask;
        mask = (MAX_IW'(1) << w) - MAX_IW'(1);
        return (iw >> lsb) & mask;
    endfunction

    // Word layout: {opcode5, rd, rs1, rs2, imm}
    function automatic logic [MAX_IW-1:0] f_imm(input logic [MAX_IW-1:0] iw, input int data_w);
        return f_slice(iw, 0, data_w);
    endfunction

    function automatic logic [MAX_IW-1:0] f_rs2(input logic [MAX_IW-1:0] iw,
                                                input int data_w, input int reg_aw);
        return f_slice(iw, data_w, reg_aw);
    endfunction

    function automatic logic [MAX_IW-1:0] f_rs1(input logic [MAX_IW-1:0] iw,
                                                input int data_w, input int reg_aw);
        return f_slice(iw, data_w + reg_aw, reg_aw);
    endfunction

    function automatic logic [MAX_IW-1:0] f_rd(input logic [MAX_IW-1:0] iw,
                                               input int data_w, input int reg_aw);
        return f_slice(iw, data_w + 2*reg_aw, reg_aw);
    endfunction

    function automatic logic [4:0] f_opcode(input logic [MAX_IW-1:0] iw,
                                            input int data_w, input int reg_aw);
        return 5'(f_slice(iw, data_w + 3*reg_aw, 5));
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_alu.sv
`default_nettype none
// ============================================================================
// Module   : risc_alu
// Purpose  : Combinational ALU for the RISC core; result plus Z/C flags.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module risc_alu
    import risc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [4:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_z,
    output logic              o_c
);

    logic [DATA_W:0] w_sum;

    // Opcode-selected operation; shifts are single-bit and use only i_a.
    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_c      = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[DATA_W-1:0];
                o_c      = w_sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                o_result = i_a - i_b;
                o_c      = (i_a < i_b);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SHL: begin
                o_result = {i_a[DATA_W-2:0], 1'b0};
                o_c      = i_a[DATA_W-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[DATA_W-1:1]};
                o_c      = i_a[0];
            end
            default: ;
        endcase
    end

    assign o_z = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/risc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : risc_core_param
// Purpose  : Parametrised multi-cycle RISC core with handshaked instruction
//            and data memories, I/O channels, bounded stack and HALT.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module risc_core_param
    import risc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 4,
    parameter int PC_W        = 8,
    parameter int ADDR_W      = 8,
    parameter int NUM_IN      = 4,
    parameter int NUM_OUT     = 4,
    parameter int STACK_DEPTH = 16,
    parameter int INSTR_W     = 5 + 3*REG_AW + DATA_W
) (
    input  logic                      clk,
    input  logic                      Reset,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]        imem_rdata,
    input  logic                      imem_ack,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wdata,
    input  logic [DATA_W-1:0]         dmem_rdata,
    input  logic                      dmem_ack,
    input  logic [NUM_IN*DATA_W-1:0]  in_ports,
    output logic [NUM_OUT*DATA_W-1:0] out_ports,
    output logic                      zflag,
    output logic                      cflag,
    output logic                      halted,
    output logic                      stack_fault
);

    localparam int c_NREG    = 2**REG_AW;
    localparam int c_DEPTH_W = $clog2(STACK_DEPTH + 1);

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [DATA_W-1:0]    r_regs [c_NREG];
    logic [DATA_W-1:0]    r_out  [NUM_OUT];
    logic [DATA_W-1:0]    r_a, r_b, r_result, r_dwdata;
    logic [ADDR_W-1:0]    r_sp, r_daddr;
    logic [c_DEPTH_W-1:0] r_depth;
    logic                 r_ireq, r_dreq, r_dwe, r_z, r_c, r_halted, r_fault;

    logic [MAX_IW-1:0]    w_iw;
    logic [4:0]           w_op;
    logic [REG_AW-1:0]    w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]    w_imm, w_ea, w_in_val, w_alu_res;
    logic                 w_alu_z, w_alu_c, w_is_alu, w_writes_rd;

    assign w_iw  = MAX_IW'(r_ir);
    assign w_op  = f_opcode(w_iw, DATA_W, REG_AW);
    assign w_rd  = REG_AW'(f_rd(w_iw, DATA_W, REG_AW));
    assign w_rs1 = REG_AW'(f_rs1(w_iw, DATA_W, REG_AW));
    assign w_rs2 = REG_AW'(f_rs2(w_iw, DATA_W, REG_AW));
    assign w_imm = DATA_W'(f_imm(w_iw, DATA_W));
    assign w_ea  = r_a + w_imm;

    // Opcodes 0..7 are the ALU group; CMP is the only one without a write-back.
    assign w_is_alu    = (w_op[4:3] == 2'b00);
    assign w_writes_rd = (w_is_alu && (w_op != OP_CMP)) || (w_op == OP_IN) ||
                         (w_op == OP_MOVI) || (w_op == OP_LD) || (w_op == OP_POP);

    risc_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_res),
        .o_z      (w_alu_z),
        .o_c      (w_alu_c)
    );

    // Input channel select; out-of-range channel numbers read as zero.
    always_comb begin
        w_in_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_imm == DATA_W'(k)) w_in_val = in_ports[k*DATA_W +: DATA_W];
        end
    end

    // Core FSM: fetch/decode/execute/memory/write-back sequencing plus all state.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_dwdata <= '0;
            r_sp     <= '1;
            r_daddr  <= '0;
            r_depth  <= '0;
            r_ireq   <= 1'b0;
            r_dreq   <= 1'b0;
            r_dwe    <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            for (int k = 0; k < c_NREG; k++) r_regs[k] <= '0;
            for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_ireq  <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        r_ireq  <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[w_rs1];
                    r_b     <= r_regs[w_rs2];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Default is straight back to fetch; paths below override.
                    r_state <= S_FETCH;
                    r_ireq  <= 1'b1;
                    if (w_is_alu) begin
                        r_result <= w_alu_res;
                        r_z      <= w_alu_z;
                        r_c      <= w_alu_c;
                        r_state  <= S_WB;
                        r_ireq   <= 1'b0;
                    end else begin
                        case (w_op)
                            OP_IN: begin
                                r_result <= w_in_val;
                                r_state  <= S_WB;
                                r_ireq   <= 1'b0;
                            end
                            OP_OUT: begin
                                for (int k = 0; k < NUM_OUT; k++) begin
                                    if (w_imm == DATA_W'(k)) r_out[k] <= r_a;
                                end
                                r_state <= S_WB;
                                r_ireq  <= 1'b0;
                            end
                            OP_MOVI: begin
                                r_result <= w_imm;
                                r_state  <= S_WB;
                                r_ireq   <= 1'b0;
                            end
                            OP_LD, OP_ST: begin
                                r_daddr  <= w_ea[ADDR_W-1:0];
                                r_dwdata <= r_b;
                                r_dwe    <= (w_op == OP_ST);
                                r_dreq   <= 1'b1;
                                r_state  <= S_MEM;
                                r_ireq   <= 1'b0;
                            end
                            OP_JMP: r_pc <= PC_W'(w_imm);
                            OP_JZ:  if (r_z) r_pc <= PC_W'(w_imm);
                            OP_JC:  if (r_c) r_pc <= PC_W'(w_imm);
                            OP_PUSH: begin
                                if (r_depth == c_DEPTH_W'(STACK_DEPTH)) begin
                                    r_fault <= 1'b1;
                                end else begin
                                    r_daddr  <= r_sp;
                                    r_dwdata <= r_b;
                                    r_dwe    <= 1'b1;
                                    r_dreq   <= 1'b1;
                                    r_state  <= S_MEM;
                                    r_ireq   <= 1'b0;
                                end
                            end
                            OP_POP: begin
                                if (r_depth == '0) begin
                                    r_fault <= 1'b1;
                                end else begin
                                    r_daddr <= r_sp + ADDR_W'(1);
                                    r_dwe   <= 1'b0;
                                    r_dreq  <= 1'b1;
                                    r_state <= S_MEM;
                                    r_ireq  <= 1'b0;
                                end
                            end
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                                r_ireq   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_dreq <= 1'b0;
                        r_dwe  <= 1'b0;
                        if (w_op == OP_PUSH) begin
                            r_sp    <= r_sp - ADDR_W'(1);
                            r_depth <= r_depth + c_DEPTH_W'(1);
                        end
                        if (w_op == OP_POP) begin
                            r_sp    <= r_sp + ADDR_W'(1);
                            r_depth <= r_depth - c_DEPTH_W'(1);
                        end
                        if (r_dwe) begin
                            r_state <= S_FETCH;
                            r_ireq  <= 1'b1;
                        end else begin
                            r_result <= dmem_rdata;
                            r_state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_writes_rd) r_regs[w_rd] <= r_result;
                    r_state <= S_FETCH;
                    r_ireq  <= 1'b1;
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_state <= S_IDLE;
                    r_ireq  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_ports[k*DATA_W +: DATA_W] = r_out[k];
    end

    assign imem_req    = r_ireq;
    assign imem_addr   = r_pc;
    assign dmem_req    = r_dreq;
    assign dmem_we     = r_dwe;
    assign dmem_addr   = r_daddr;
    assign dmem_wdata  = r_dwdata;
    assign zflag       = r_z;
    assign cflag       = r_c;
    assign halted      = r_halted;
    assign stack_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_risc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_core_param
// Purpose  : Directed self-checking bench for risc_core_param (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_core_param;

    localparam logic [4:0] c_ADD  = 5'b00000;
    localparam logic [4:0] c_SUB  = 5'b00001;
    localparam logic [4:0] c_CMP  = 5'b00111;
    localparam logic [4:0] c_IN   = 5'b01000;
    localparam logic [4:0] c_OUT  = 5'b01001;
    localparam logic [4:0] c_MOVI = 5'b01010;
    localparam logic [4:0] c_ST   = 5'b01100;
    localparam logic [4:0] c_JZ   = 5'b01110;
    localparam logic [4:0] c_JC   = 5'b01111;
    localparam logic [4:0] c_PUSH = 5'b10000;
    localparam logic [4:0] c_POP  = 5'b10001;
    localparam logic [4:0] c_HALT = 5'b11111;

    logic        clk = 1'b0;
    logic        Reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
    logic [24:0] imem_rdata;
    logic [31:0] in_ports, out_ports;
    logic        zflag, cflag, halted, stack_fault;

    bit [24:0] imem [256];
    bit [7:0]  dmem [256];
    int        idelay, ddelay, icnt, dcnt;
    int        cyc, d_cnt, d_wr;
    int        fetch_cyc [256];
    logic [7:0] d_last_addr;
    logic [7:0] fetch_q [$];
    int        n_checks = 0;
    int        n_fail   = 0;

    risc_core_param dut (
        .clk(clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .in_ports(in_ports), .out_ports(out_ports),
        .zflag(zflag), .cflag(cflag), .halted(halted), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign imem_ack   = imem_req && (icnt >= idelay);
    assign dmem_ack   = dmem_req && (dcnt >= ddelay);

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    initial begin
        cyc = 0; d_cnt = 0; d_wr = 0; d_last_addr = '0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (imem_req && imem_ack) begin
            fetch_cyc[imem_addr] = cyc;
            fetch_q.push_back(imem_addr);
        end
        if (dmem_req && dmem_ack) begin
            d_cnt = d_cnt + 1;
            d_last_addr = dmem_addr;
            if (dmem_we) begin
                dmem[dmem_addr] = dmem_wdata;
                d_wr = d_wr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [24:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [7:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = enc(c_HALT, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req, qb, found;
        logic stable;
        Reset = 1'b1; in_ports = '0; idelay = 0; ddelay = 0;

        // ---- ALU add with carry/zero, OUT, latencies ----
        clear_imem();
        imem[0] = enc(c_MOVI, 1, 0, 0, 8'h05);
        imem[1] = enc(c_MOVI, 2, 0, 0, 8'hFB);
        imem[2] = enc(c_OUT,  0, 1, 0, 8'h00);
        imem[3] = enc(c_ADD,  3, 1, 2, 8'h00);
        imem[4] = enc(c_OUT,  0, 3, 0, 8'h00);
        repeat (2) @(negedge clk);
        check("rst_out_ports", out_ports, 32'h0);
        check("rst_flags", {28'd0, zflag, cflag, halted, stack_fault}, 32'h0);
        check("rst_dmem_req_we", {30'd0, dmem_req, dmem_we}, 32'h0);
        Reset = 1'b0;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_fetch_req", {31'd0, imem_req}, 32'd1);
        check("first_fetch_addr", {24'd0, imem_addr}, 32'h0);
        wait_halt(200);
        check("add_out_ch0", out_ports, 32'h0000_0000);
        check("add_zflag", {31'd0, zflag}, 32'd1);
        check("add_cflag", {31'd0, cflag}, 32'd1);
        check("add_latency", fetch_cyc[4] - fetch_cyc[3], 32'd4);
        check("movi_latency", fetch_cyc[1] - fetch_cyc[0], 32'd4);
        check("halt_no_req", {31'd0, imem_req}, 32'd0);

        // ---- slow instruction fetch ----
        clear_imem();
        imem[0] = enc(c_MOVI, 1, 0, 0, 8'h01);
        idelay = 3;
        do_reset();
        n_req = 0; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                n_req++;
                if (imem_addr != 8'h00) stable = 1'b0;
            end
            if (imem_ack) break;
        end
        check("slow_fetch_req_cycles", n_req, 32'd4);
        check("slow_fetch_addr_stable", {31'd0, stable}, 32'd1);
        @(negedge clk);
        check("slow_fetch_pc_after_ack", {24'd0, imem_addr}, 32'h01);
        check("slow_fetch_req_dropped", {31'd0, imem_req}, 32'd0);
        wait_halt(200);
        idelay = 0;

        // ---- stack overflow and LIFO pop ----
        clear_imem();
        for (int k = 1; k <= 16; k++) begin
            imem[2*(k-1)]   = enc(c_MOVI, 1, 0, 0, 8'(k));
            imem[2*(k-1)+1] = enc(c_PUSH, 0, 0, 1, 8'h00);
        end
        imem[32] = enc(c_PUSH, 0, 0, 1, 8'h00);
        imem[33] = enc(c_POP,  5, 0, 0, 8'h00);
        imem[34] = enc(c_OUT,  0, 5, 0, 8'h01);
        begin
            int c0, w0;
            c0 = d_cnt; w0 = d_wr;
            do_reset();
            wait_halt(600);
            check("stack_fault_set", {31'd0, stack_fault}, 32'd1);
            check("stack_writes", d_wr - w0, 32'd16);
            check("stack_accesses", d_cnt - c0, 32'd17);
            check("pop_addr_sp_plus1", {24'd0, d_last_addr}, 32'hF0);
            check("pop_lifo_r5", out_ports, 32'h0000_1000);
            check("push_first_slot", {24'd0, dmem[8'hFF]}, 32'h01);
            check("push_last_slot", {24'd0, dmem[8'hF0]}, 32'h10);
        end

        // ---- IN / OUT channel selection ----
        clear_imem();
        in_ports = {8'h11, 8'hA5, 8'h77, 8'h33};
        imem[0] = enc(c_IN,   4, 0, 0, 8'h02);
        imem[1] = enc(c_OUT,  0, 4, 0, 8'h03);
        imem[2] = enc(c_OUT,  0, 4, 0, 8'h00);
        imem[3] = enc(c_IN,   6, 0, 0, 8'h05);
        imem[4] = enc(c_OUT,  0, 6, 0, 8'h00);
        imem[5] = enc(c_MOVI, 7, 0, 0, 8'h3C);
        imem[6] = enc(c_OUT,  0, 7, 0, 8'h07);
        do_reset();
        wait_halt(200);
        check("io_out_ports", out_ports, 32'hA500_0000);
        check("io_flags_untouched", {30'd0, zflag, cflag}, 32'd0);
        check("io_fault_cleared", {31'd0, stack_fault}, 32'd0);
        check("in_latency", fetch_cyc[1] - fetch_cyc[0], 32'd4);

        // ---- SUB borrow, CMP, JZ taken, JC not taken ----
        clear_imem();
        imem[0]     = enc(c_MOVI, 2, 0, 0, 8'h5E);
        imem[1]     = enc(c_MOVI, 3, 0, 0, 8'h01);
        imem[2]     = enc(c_SUB,  4, 0, 3, 8'h00);
        imem[3]     = enc(c_MOVI, 1, 0, 0, 8'h22);
        imem[4]     = enc(c_CMP,  2, 1, 1, 8'h00);
        imem[5]     = enc(c_JZ,   0, 0, 0, 8'h10);
        imem[8'h10] = enc(c_JC,   0, 0, 0, 8'h30);
        imem[8'h11] = enc(c_OUT,  0, 2, 0, 8'h00);
        imem[8'h12] = enc(c_OUT,  0, 4, 0, 8'h01);
        qb = fetch_q.size();
        do_reset();
        wait_halt(300);
        check("cmp_zflag", {31'd0, zflag}, 32'd1);
        check("cmp_cflag", {31'd0, cflag}, 32'd0);
        found = (fetch_q.size() > qb + 7) ? 1 : 0;
        check("branch_trace_len", found, 32'd1);
        if (found == 1) begin
            check("jz_target", {24'd0, fetch_q[qb+6]}, 32'h10);
            check("jc_fallthrough", {24'd0, fetch_q[qb+7]}, 32'h11);
        end
        check("jz_latency", fetch_cyc[8'h10] - fetch_cyc[5], 32'd3);
        check("jc_latency", fetch_cyc[8'h11] - fetch_cyc[8'h10], 32'd3);
        check("cmp_no_wb_sub_borrow", out_ports, 32'h0000_FF5E);

        // ---- reset during a stalled store ----
        clear_imem();
        imem[0] = enc(c_MOVI, 1, 0, 0, 8'h40);
        imem[1] = enc(c_MOVI, 2, 0, 0, 8'h99);
        imem[2] = enc(c_ST,   0, 1, 2, 8'h02);
        ddelay = 5;
        do_reset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req) begin
                found = 1;
                break;
            end
        end
        check("st_req_seen", found, 32'd1);
        check("st_we", {31'd0, dmem_we}, 32'd1);
        check("st_addr", {24'd0, dmem_addr}, 32'h42);
        check("st_wdata", {24'd0, dmem_wdata}, 32'h99);
        @(negedge clk);
        check("st_addr_stable", {23'd0, dmem_req, dmem_addr}, 32'h142);
        begin
            int w0;
            w0 = d_wr;
            #2 Reset = 1'b1;
            #1;
            check("async_drop_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
            repeat (2) @(negedge clk);
            check("rst_pc_zero", {24'd0, imem_addr}, 32'h0);
            check("st_not_written", d_wr - w0, 32'd0);
            check("st_mem_untouched", {24'd0, dmem[8'h42]}, 32'h00);
        end
        ddelay = 0;
        Reset = 1'b0;
        check("rerst_idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("rerst_first_req", {31'd0, imem_req}, 32'd1);
        wait_halt(200);
        check("st_after_rerun", {24'd0, dmem[8'h42]}, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
